frame_copy_engine: RTL and testbench
====================================

FRAME_COPY_ENGINE -- requirements
Module: frame_copy_engine

Interface
REQ-001 SHALL have parameter PIXELS, default 76800, number of pixels copied per frame (320x240).
REQ-002 SHALL have parameter ADDR_W, default 17, address width of source and destination memories.
REQ-003 SHALL have parameter DATA_W, default 8, pixel width (RGB332).
REQ-004 SHALL have parameter RD_LAT, default 2, source memory read latency in cycles (range 1..4).
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 start  in  1  request a copy; sampled only in IDLE.
REQ-008 abort  in  1  synchronous cancel of a copy in progress.
REQ-009 rd_en  out  1  source read strobe.
REQ-010 rd_addr  out  ADDR_W  source read address.
REQ-011 rd_data  in  DATA_W  source read data, valid RD_LAT cycles after the matching rd_en.
REQ-012 wr_en  out  1  destination write strobe.
REQ-013 wr_addr  out  ADDR_W  destination write address.
REQ-014 wr_data  out  DATA_W  destination write data.
REQ-015 busy  out  1  high from the cycle after start is accepted until done.
REQ-016 done  out  1  one-cycle pulse after the last write.

Function
REQ-017 States SHALL be IDLE, STREAM, DRAIN and FINISH; all outputs registered.
REQ-018 IDLE: start=1 -> STREAM next cycle; rd_addr=0 and rd_en=1 in the first STREAM cycle.
REQ-019 STREAM: one read per cycle; rd_addr increments by 1; after rd_addr=PIXELS-1 is issued -> DRAIN, rd_en=0.
REQ-020 Each issued read SHALL produce exactly one write: the address issued in cycle k has wr_en=1, wr_addr=that address and wr_data=rd_data in cycle k+RD_LAT+1.
REQ-021 The write-side address and valid SHALL be carried by an RD_LAT-deep delay line; no read/write counter comparison.
REQ-022 DRAIN: exits to FINISH in the cycle the write to PIXELS-1 is presented.
REQ-023 FINISH: done=1 and busy=0 for exactly one cycle, then IDLE.
REQ-024 Throughput SHALL be one pixel per cycle; total start-to-done latency = PIXELS+RD_LAT+2 cycles.
REQ-025 start while busy SHALL be ignored (no restart, no queueing).
REQ-026 abort in STREAM or DRAIN SHALL force rd_en=0 and wr_en=0 from the next cycle, flush the delay line, -> IDLE; done SHALL NOT pulse.
REQ-027 Simultaneous start and abort in IDLE: abort wins, copy not started.
REQ-028 rd_addr SHALL never exceed PIXELS-1; the counter SHALL not wrap.
REQ-029 wr_en SHALL be 0 whenever busy=0, apart from the final write cycle.

Reset
REQ-030 Reset low SHALL asynchronously force IDLE, with rd_en, wr_en, busy and done at 0 and rd_addr, wr_addr and wr_data at 0.
REQ-031 Reset mid-copy SHALL clear the delay line; no write SHALL occur after reset release until a new start.

Configuration
REQ-032 Macro FRAME_COPY_CLEAR_EN defined: adds inputs clear (1) and fill_color (DATA_W); start with clear=1 writes fill_color to all PIXELS addresses, rd_en stays 0, and latency = PIXELS+2.
REQ-033 FRAME_COPY_CLEAR_EN undefined: the ports and logic are absent and every start performs a copy.

Structure
REQ-034 Package frame_copy_pkg SHALL hold the state enum, FRAME_W=320, FRAME_H=240, default PIXELS and DATA_W.
REQ-035 Sub-module lat_pipe (parameterised depth and width, valid+address shift register with flush) SHALL implement the delay line.

Verification (PIXELS=16, RD_LAT=2, source model returns data=addr^8'hA5)
REQ-036 Start pulse -> 16 writes, addresses 0..15, data addr^A5, consecutive cycles; done 20 cycles after start.
REQ-037 Start held high for the whole copy -> exactly one copy, one done pulse.
REQ-038 Abort in cycle 6 of STREAM -> wr_en low from the next cycle, no done, busy=0; later start gives a full correct copy.
REQ-039 Reset asserted mid-DRAIN -> all outputs 0 immediately, no further writes after release.
REQ-040 With FRAME_COPY_CLEAR_EN, clear=1 and fill_color=8'hE0 -> 16 writes of E0, rd_en never high, done 18 cycles after start.

Source files
------------

// File: rtl/frame_copy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_copy_pkg
// Purpose  : Shared frame geometry, default sizes and FSM state encoding
//            for the frame copy engine.
// Revision : 1.0 - initial release
// ============================================================================
package frame_copy_pkg;

    localparam int FRAME_W        = 320;
    localparam int FRAME_H        = 240;
    localparam int DEFAULT_PIXELS = FRAME_W * FRAME_H;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lat_pipe
// Purpose  : DEPTH-stage valid + data shift register with synchronous flush.
//            Carries each issued read address alongside the source memory
//            latency so the write side needs no counters of its own.
// Revision : 1.0 - initial release
// ============================================================================
module lat_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             r_valid [DEPTH];
    logic [WIDTH-1:0] r_data  [DEPTH];

    // Shift valid/data one stage per cycle; flush empties every stage at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_data[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_data[i]  <= '0;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_data[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/frame_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : frame_copy_engine
// Purpose  : Streams PIXELS words from a source memory to a destination
//            memory at one pixel per cycle. The read address is delayed by
//            RD_LAT stages so each write pairs with its returning read data.
//            Optional macro FRAME_COPY_CLEAR_EN adds a fill mode (clear,
//            fill_color) that writes a constant without reading the source.
// Revision : 1.0 - initial release
// ============================================================================
module frame_copy_engine
    import frame_copy_pkg::*;
#(
    parameter int PIXELS = DEFAULT_PIXELS,
    parameter int ADDR_W = 17,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
`ifdef FRAME_COPY_CLEAR_EN
    input  logic              clear,
    input  logic [DATA_W-1:0] fill_color,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_issue;        // rd_addr holds a live address this cycle
    logic               w_abort;
    logic               w_last_issue;
    logic               w_last_write;
    logic               w_pipe_valid;
    logic [ADDR_W-1:0]  w_pipe_addr;
    logic               w_clear_start;
    logic               w_clear_mode;
    logic [DATA_W-1:0]  w_fill;

`ifdef FRAME_COPY_CLEAR_EN
    logic r_clear_mode;

    // Capture the job type when a start is accepted; held for the whole job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clear_mode <= 1'b0;
        end else if (r_state == IDLE && w_next == STREAM) begin
            r_clear_mode <= clear;
        end
    end

    assign w_clear_start = clear;
    assign w_clear_mode  = r_clear_mode;
    assign w_fill        = fill_color;
`else
    assign w_clear_start = 1'b0;
    assign w_clear_mode  = 1'b0;
    assign w_fill        = '0;
`endif

    assign w_abort      = abort && (r_state == STREAM || r_state == DRAIN);
    assign w_last_issue = r_issue && (rd_addr == LAST_ADDR);
    assign w_last_write = w_pipe_valid && (w_pipe_addr == LAST_ADDR);

    lat_pipe #(
        .DEPTH (RD_LAT),
        .WIDTH (ADDR_W)
    ) u_lat_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_abort),
        .in_valid  (rd_en),
        .in_data   (rd_addr),
        .out_valid (w_pipe_valid),
        .out_data  (w_pipe_addr)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: abort beats start in IDLE; fill jobs skip DRAIN (no read latency)
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_next = STREAM;
                end
            end
            STREAM: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_last_issue) begin
                    w_next = w_clear_mode ? FINISH : DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_last_write) begin
                    w_next = FINISH;
                end
            end
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Registered outputs: read issue, write presentation and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy    <= (w_next != IDLE);
            done    <= (r_state == FINISH);
            r_issue <= (w_next == STREAM);

            if (r_state == IDLE) begin
                rd_addr <= '0;
                rd_en   <= (w_next == STREAM) && !w_clear_start;
            end else if (w_next == STREAM) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                rd_en   <= !w_clear_mode;
            end else begin
                rd_en   <= 1'b0;
            end

            if (w_abort) begin
                wr_en <= 1'b0;
            end else if (w_clear_mode) begin
                wr_en <= r_issue;
                if (r_issue) begin
                    wr_addr <= rd_addr;
                    wr_data <= w_fill;
                end
            end else begin
                wr_en <= w_pipe_valid;
                if (w_pipe_valid) begin
                    wr_addr <= w_pipe_addr;
                    wr_data <= rd_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_copy_engine
// Purpose  : Scoreboard bench for frame_copy_engine with PIXELS=16, RD_LAT=2.
//            Source memory returns addr^A5 two cycles after each read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_copy_engine;

    localparam int PIX = 16;
    localparam int LAT = 2;
    localparam int AW  = 17;
    localparam int DW  = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
`ifdef FRAME_COPY_CLEAR_EN
    logic          clear      = 1'b0;
    logic [DW-1:0] fill_color = '0;
`endif

    frame_copy_engine #(
        .PIXELS (PIX),
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
`ifdef FRAME_COPY_CLEAR_EN
        .clear      (clear),
        .fill_color (fill_color),
`endif
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Source memory model: two-cycle read latency, data = addr ^ A5
    logic          src_v0 = 1'b0, src_v1 = 1'b0;
    logic [AW-1:0] src_a0 = '0,   src_a1 = '0;
    always @(posedge clk) begin
        src_v0 <= rd_en;
        src_a0 <= rd_addr;
        src_v1 <= src_v0;
        src_a1 <= src_a0;
    end
    assign rd_data = src_v1 ? (src_a1[7:0] ^ 8'hA5) : 8'h00;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    wr_t mon_e;
    int  checks  = 0;
    int  errors  = 0;
    int  rd_seen = 0;
    int  s;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_writes(input int first, input int n, input bit use_fill, input int fill);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = i;
            e.data = use_fill ? fill : ((i ^ 'hA5) & 'hFF);
            e.cyc  = first + i;
            wq.push_back(e);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((wq.size() != 0 || dq.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending writes=%0d dones=%0d required 0", wq.size(), dq.size());
            wq.delete();
            dq.delete();
        end
        repeat (8) tick();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or done
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%0h cyc=%0d required none", wr_addr, wr_data, cyc);
                end else begin
                    mon_e = wq.pop_front();
                    if (int'(wr_addr) != mon_e.addr || int'(wr_data) != mon_e.data || cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%0h cyc=%0d required addr=%0d data=%0h cyc=%0d",
                                 wr_addr, wr_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                    end
                end
                checks++;
                if (!busy) begin
                    errors++;
                    $display("FAIL write_busy: got busy=0 required 1 at cyc=%0d", cyc);
                end
            end
            if (done) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: cyc=%0d required none", cyc);
                end else if (dq[0] != cyc || busy) begin
                    errors++;
                    $display("FAIL done: got cyc=%0d busy=%0d required cyc=%0d busy=0", cyc, busy, dq[0]);
                    void'(dq.pop_front());
                end else begin
                    void'(dq.pop_front());
                end
            end
            if (rd_en) begin
                rd_seen++;
                checks++;
                if (rd_addr > AW'(PIX - 1)) begin
                    errors++;
                    $display("FAIL rd_addr_range: got %0d required <= %0d", rd_addr, PIX - 1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en",   rd_en,   0);
        check("rst_wr_en",   wr_en,   0);
        check("rst_busy",    busy,    0);
        check("rst_done",    done,    0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single start pulse: 16 writes from s+4, done at s+20
        start = 1'b1;
        s = cyc;
        push_writes(s + LAT + 2, PIX, 1'b0, 0);
        dq.push_back(s + PIX + LAT + 2);
        tick();
        start = 1'b0;
        check("first_busy",    busy,    1);
        check("first_rd_en",   rd_en,   1);
        check("first_rd_addr", rd_addr, 0);
        wait_drain(60);
        check("idle_busy_1", busy, 0);

        // Start held through the whole copy: exactly one copy
        start = 1'b1;
        s = cyc;
        push_writes(s + LAT + 2, PIX, 1'b0, 0);
        dq.push_back(s + PIX + LAT + 2);
        repeat (PIX + LAT + 2) tick();
        start = 1'b0;
        wait_drain(60);
        check("idle_busy_2", busy, 0);

        // Abort in the sixth STREAM cycle: only addresses 0..2 get written
        start = 1'b1;
        s = cyc;
        push_writes(s + LAT + 2, 3, 1'b0, 0);
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("abort_rd_addr", rd_addr, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy",  busy,  0);
        check("abort_wr_en", wr_en, 0);
        check("abort_rd_en", rd_en, 0);
        wait_drain(30);

        // Full copy after abort
        start = 1'b1;
        s = cyc;
        push_writes(s + LAT + 2, PIX, 1'b0, 0);
        dq.push_back(s + PIX + LAT + 2);
        tick();
        start = 1'b0;
        wait_drain(60);

        // Start and abort together in IDLE: nothing happens
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("startabort_busy",  busy,  0);
        check("startabort_rd_en", rd_en, 0);
        repeat (10) tick();

        // Reset in DRAIN: writes 0..12 seen, then everything cleared
        start = 1'b1;
        s = cyc;
        push_writes(s + LAT + 2, 13, 1'b0, 0);
        tick();
        start = 1'b0;
        repeat (16) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_rd_en",   rd_en,   0);
        check("midrst_wr_en",   wr_en,   0);
        check("midrst_busy",    busy,    0);
        check("midrst_done",    done,    0);
        check("midrst_rd_addr", rd_addr, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (25) tick();
        wait_drain(10);
        check("postrst_busy", busy, 0);

        // Copy after reset
        start = 1'b1;
        s = cyc;
        push_writes(s + LAT + 2, PIX, 1'b0, 0);
        dq.push_back(s + PIX + LAT + 2);
        tick();
        start = 1'b0;
        wait_drain(60);

`ifdef FRAME_COPY_CLEAR_EN
        // Fill with E0: no reads, writes from s+2, done at s+18
        clear      = 1'b1;
        fill_color = 8'hE0;
        start      = 1'b1;
        s = cyc;
        rd_seen = 0;
        push_writes(s + 2, PIX, 1'b1, 'hE0);
        dq.push_back(s + PIX + 2);
        tick();
        start = 1'b0;
        clear = 1'b0;
        wait_drain(60);
        check("clear_rd_en_count", rd_seen, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
